button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
Conditions the raw active-low push buttons (start, stop) from the board before they reach the dice state machine. Each button goes through:
- a two-flop synchronizer;
- a per-button debounce counter and four-state FSM;
- registered outputs: a clean active-high pressed level and one-cycle press/release pulses.

The dice controller consumes the press pulses instead of raw pin levels, so contact bounce cannot toggle its Espera/Dado state.

Parameters:
N_BTN, 2, number of independent button channels (bit 0 = start, bit 1 = stop in the dice top level)
DEBOUNCE_CYCLES, 1_000_000, consecutive stable clk cycles required to accept a change (20 ms at 50 MHz); legal range 2..2^24
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden)

Ports:
clk  input  1  50 MHz system clock
rst_n  input  1  asynchronous, active-low reset
btn_raw_n  input  N_BTN  raw button pins, active-low (0 = pressed), asynchronous to clk
btn_level  output  N_BTN  debounced level, active-high (1 = pressed)
btn_press  output  N_BTN  one-cycle pulse on accepted press
btn_release  output  N_BTN  one-cycle pulse on accepted release

Behaviour:
- One clock; reset is asynchronous and active-low; rst_n assertion takes effect immediately, release is sampled on clk.
- Reset values:
  - synchronizer flops = 1 (released);
  - FSM = UP, counters = 0;
  - btn_level = 0, btn_press = 0, btn_release = 0.
- Synchronizer: s1 <= btn_raw_n, s2 <= s1; the FSM sees only p = ~s2 (1 = pressed).
- Per-channel FSM (channels fully independent, no shared state):
  - UP: level 0. If p=1, go to PEND_DN and set cnt=1; else stay with cnt=0.
  - PEND_DN: if p=0, return to UP and set cnt=0 (bounce rejected, no pulse). Else if cnt == DEBOUNCE_CYCLES-1, go to DOWN, set btn_level=1, pulse btn_press, set cnt=0. Else cnt+1.
  - DOWN: level 1. If p=0, go to PEND_UP and set cnt=1.
  - PEND_UP: mirror of PEND_DN. A return to p=1 goes back to DOWN with no pulse. On completion go to UP, set btn_level=0, pulse btn_release.
- Acceptance: a change is accepted only after p has held the new value for exactly DEBOUNCE_CYCLES consecutive clk cycles.
- Latency: raw edge held steady -> btn_level change after exactly 2 + DEBOUNCE_CYCLES rising edges, counted from the first edge that samples the new raw value.
- Pulses:
  - btn_press/btn_release are high for exactly one cycle, coincident with the first cycle btn_level shows the new value;
  - never both high on the same channel in the same cycle;
  - at most one press pulse per accepted press, regardless of hold duration.
- Counter: never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Simultaneous events: multiple channels may pulse in the same cycle; the consumer resolves priority.
- Reset mid-operation: any state (including PEND_*) returns to UP with level 0 and no pulse.
  - A button held through reset release is seen as a new press: btn_press fires 2 + DEBOUNCE_CYCLES cycles after rst_n deasserts.
- All outputs are registered; no combinational path from btn_raw_n to any output.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, N_BTN=2.
1. Reset: hold rst_n=0 with btn_raw_n=2'b00 -> all outputs 0. Release rst_n with buttons still held -> btn_level=2'b11 and btn_press=2'b11 for one cycle exactly 10 edges later.
2. Clean press/release ch0: btn_raw_n[0] low at edge 0 -> btn_press[0]=1 only in cycle 10 and btn_level[0]=1 from cycle 10. Raise the pin at edge 30 -> btn_release[0]=1 only in cycle 40 and level 0 from then.
3. Bounce rejection: toggle btn_raw_n[0] low 5 cycles / high 3 / low 7 / high, repeated 10 times -> btn_level[0] stays 0 and no pulses. Then hold low 8+ cycles -> exactly one btn_press[0].
4. Release glitch: while level=1, drive the pin high for 7 cycles then low -> level stays 1 and no btn_release.
5. Independence/simultaneity: press both channels on the same edge -> both press bits pulse in the same cycle. Bounce ch1 while ch0 is held -> ch0 outputs unaffected.
6. Async reset mid-count: assert rst_n=0 while ch0 is in PEND_DN with cnt=5 -> outputs 0 immediately, before the next clk edge. After release, the count restarts from 0.

Source files
------------

// File: rtl/button_conditioner.sv
// Conditions raw active-low push buttons: two-flop synchronizer, per-channel
// debounce FSM, and registered active-high level plus one-cycle press/release pulses.
module button_conditioner #(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw_n,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_UP,
    ST_PEND_DN,
    ST_DOWN,
    ST_PEND_UP
  } state_t;

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] pressed;

  // Synchronizer resets to the released (high) pin level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn_raw_n;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ~sync2_q;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= ST_UP;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // cnt counts consecutive cycles the new value has held; the pending state
    // itself is the first of those cycles, so a change completes at CNT_LAST.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        ST_UP: begin
          if (pressed[g]) begin
            state_d = ST_PEND_DN;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        ST_PEND_DN: begin
          if (!pressed[g]) begin
            state_d = ST_UP;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_DOWN;
            level_d = 1'b1;
            press_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_DOWN: begin
          if (!pressed[g]) begin
            state_d = ST_PEND_UP;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        ST_PEND_UP: begin
          if (pressed[g]) begin
            state_d = ST_DOWN;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = ST_UP;
            level_d   = 1'b0;
            release_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_UP;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
  end

endmodule
